bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter BUS_TIMEOUT, default 100, is the cycle budget for one transaction, measured from bus_req_o rise to completion; legal range 2..2^32-1.
REQ-002 clk_i  input  1  single clock; all logic on posedge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i  input  1  command offer.
REQ-005 cmd_ready_o  output  1  command accept; a command transfers when cmd_valid_i && cmd_ready_o.
REQ-006 cmd_we_i  input  1  1=write, 0=read.
REQ-007 cmd_addr_i  input  32  byte address.
REQ-008 cmd_be_i  input  4  byte enables.
REQ-009 cmd_wdata_i  input  32  write data.
REQ-010 res_valid_o  output  1  one-cycle completion pulse.
REQ-011 res_err_o  output  1  timeout flag, qualified by res_valid_o.
REQ-012 res_rdata_o  output  32  read data, qualified by res_valid_o.
REQ-013 bus_req_o / bus_we_o  output  1 / 1  bus request and direction.
REQ-014 bus_addr_bo / bus_be_bo / bus_wdata_bo  output  32 / 4 / 32  request payload.
REQ-015 bus_ack_i  input  1  responder accepted the request (may be combinational from bus_req_o).
REQ-016 bus_resp_i / bus_rdata_bi  input  1 / 32  read response strobe and data.

Function
REQ-017 FSM states: IDLE, REQ, WAIT_RESP, DONE. All outputs are registered.
REQ-018 IDLE: cmd_ready_o=1. On a command transfer, latch we, addr, be and wdata, clear the timeout counter, and go to REQ.
REQ-019 REQ: bus_req_o=1 and the payload is held stable until bus_ack_i is sampled high; cmd_ready_o=0.
REQ-020 REQ with bus_ack_i=1 and we=1: go to DONE with err=0; bus_resp_i is not awaited.
REQ-021 REQ with bus_ack_i=1 and we=0: if bus_resp_i=1 in the same cycle, capture bus_rdata_bi and go to DONE; otherwise go to WAIT_RESP.
REQ-022 WAIT_RESP: bus_req_o=0. When bus_resp_i=1, capture bus_rdata_bi and go to DONE.
REQ-023 Timeout counter increments every cycle in REQ and WAIT_RESP. When it reaches BUS_TIMEOUT-1 without completion, go to DONE with err=1 and rdata=0; bus_req_o drops the next cycle.
REQ-024 Completion in the same cycle the counter reaches BUS_TIMEOUT-1 takes priority over timeout (err=0).
REQ-025 DONE: res_valid_o=1 for exactly one cycle, with res_err_o and res_rdata_o valid (rdata=0 for writes); then go to IDLE.
REQ-026 res_err_o and res_rdata_o hold their values until the next DONE.
REQ-027 Minimum latency, command transfer to res_valid_o: 2 cycles (ack in the first REQ cycle). The next command is accepted in the cycle after DONE.
REQ-028 bus_resp_i in IDLE, REQ-before-ack, or DONE is ignored and never produces res_valid_o.
REQ-029 cmd_valid_i while cmd_ready_o=0 is ignored; the offer stays pending, never queued.

Reset
REQ-030 On rst_i, go to IDLE immediately (asynchronously).
REQ-031 Reset values: bus_req_o=0, bus_we_o=0, bus_addr_bo=0, bus_be_bo=0, bus_wdata_bo=0, res_valid_o=0, res_err_o=0, res_rdata_o=0, counter=0, cmd_ready_o=1 after release.
REQ-032 Reset mid-transaction abandons the transfer with no res_valid_o pulse; a late bus_resp_i after release is ignored per REQ-028.

Structure
REQ-033 Shared package bus_pkg holds the FSM state enum, the 32-bit address/data and 4-bit BE width constants, and the timeout counter width ($clog2 of BUS_TIMEOUT).
REQ-034 Single flat module; no sub-modules.

Verification
REQ-035 Write: addr 0x0, data 0xA5, BE 0xF, ack=req combinational -> one bus_req_o cycle; res_valid_o 2 cycles after transfer; err=0, rdata=0.
REQ-036 Read: addr 0x80000004, ack=req combinational, resp 2 cycles after ack with 0xDEADBEEF -> res_valid_o with rdata 0xDEADBEEF, err=0.
REQ-037 Timeout: BUS_TIMEOUT=100, ack never asserted -> bus_req_o high 100 cycles; res_valid_o with err=1, rdata=0; next command accepted.
REQ-038 Race: read whose bus_resp_i arrives in the same cycle the counter reaches 99 -> err=0, data captured.
REQ-039 Reset: assert rst_i during WAIT_RESP, then inject bus_resp_i after release -> no res_valid_o, all outputs at reset values.
REQ-040 Back-to-back: cmd_valid_i held high for 3 writes -> each accepted only in IDLE, 3 res_valid_o pulses, payload stable while bus_ack_i=0 (ack stalled 3 cycles on the 2nd write).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus initiator: FSM states, payload widths and
// the helper that sizes the transaction timeout counter.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } bus_state_e;

  // The counter only has to reach BUS_TIMEOUT-1, so $clog2 bits are enough.
  function automatic int timeout_cnt_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: takes one command, runs a req/ack(/resp)
// transaction under a cycle budget and reports completion or timeout in one pulse.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [BE_W-1:0]   cmd_be_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              res_valid_o,
  output logic              res_err_o,
  output logic [DATA_W-1:0] res_rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_bo,
  output logic [BE_W-1:0]   bus_be_bo,
  output logic [DATA_W-1:0] bus_wdata_bo,
  input  logic              bus_ack_i,
  input  logic              bus_resp_i,
  input  logic [DATA_W-1:0] bus_rdata_bi
);

  localparam int               CNT_W    = timeout_cnt_w(BUS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              expired;

  logic              cmd_ready_d;
  logic              res_valid_d;
  logic              res_err_d;
  logic [DATA_W-1:0] res_rdata_d;
  logic              bus_req_d;
  logic              bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [BE_W-1:0]   bus_be_d;
  logic [DATA_W-1:0] bus_wdata_d;

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = 1'b0;
    res_valid_d = 1'b0;
    bus_req_d   = 1'b0;
    res_err_d   = res_err_o;
    res_rdata_d = res_rdata_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_bo;
    bus_be_d    = bus_be_bo;
    bus_wdata_d = bus_wdata_bo;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          state_d     = REQ;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = cmd_we_i;
          bus_addr_d  = cmd_addr_i;
          bus_be_d    = cmd_be_i;
          bus_wdata_d = cmd_wdata_i;
        end
      end

      // Completion is tested before expiry so a last-cycle finish is not an error.
      REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus_ack_i && (bus_we_o || bus_resp_i)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_rdata_d = bus_we_o ? '0 : bus_rdata_bi;
        end else if (expired) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_rdata_d = '0;
        end else if (bus_ack_i) begin
          state_d = WAIT_RESP;
        end else begin
          bus_req_d = 1'b1;
        end
      end

      WAIT_RESP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus_resp_i) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_rdata_d = bus_rdata_bi;
        end else if (expired) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_rdata_d = '0;
        end
      end

      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_ready_o  <= 1'b1;
      res_valid_o  <= 1'b0;
      res_err_o    <= 1'b0;
      res_rdata_o  <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_bo  <= '0;
      bus_be_bo    <= '0;
      bus_wdata_bo <= '0;
    end else begin
      cmd_ready_o  <= cmd_ready_d;
      res_valid_o  <= res_valid_d;
      res_err_o    <= res_err_d;
      res_rdata_o  <= res_rdata_d;
      bus_req_o    <= bus_req_d;
      bus_we_o     <= bus_we_d;
      bus_addr_bo  <= bus_addr_d;
      bus_be_bo    <= bus_be_d;
      bus_wdata_bo <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: transaction-level outcome model plus a scripted responder,
// compared against the DUT on every cycle, with literal anchors on key scenarios.
module tb_bus_initiator;

  localparam int T = 100;

  logic        clk_gen = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        res_valid_o;
  logic        res_err_o;
  logic [31:0] res_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_bo;
  logic [3:0]  bus_be_bo;
  logic [31:0] bus_wdata_bo;
  logic        bus_ack_i;
  logic        bus_resp_i = 1'b0;
  logic [31:0] bus_rdata_bi = '0;
  logic        ack_win = 1'b0;

  assign bus_ack_i = bus_req_o & ack_win;

  bus_initiator #(.BUS_TIMEOUT(T)) dut (
    .clk_i(clk_gen), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .res_valid_o(res_valid_o), .res_err_o(res_err_o), .res_rdata_o(res_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
    .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
    .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
  );

  always #5 clk_gen = ~clk_gen;

  // One transaction as the responder will play it: ack after a REQ cycles
  // (a<0: never), resp r cycles after the ack cycle, plus the outcome it must give.
  typedef struct packed {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          a;
    int          r;
    logic [31:0] d;
    int          c;
    bit          err;
    logic [31:0] rdata;
    int          reqlen;
  } plan_t;

  plan_t       pend, cur;
  int          cyc = 0, P = 0;
  bit          active = 1'b0, xfer = 1'b0;
  bit          m_ready = 1'b1, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          noise_en = 1'b0, resp_force = 1'b0;
  int          checks = 0, errors = 0;
  int          vld_cnt = 0, last_vld_cyc = 0, req_run = 0, last_req_len = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome from the rules alone: index c (REQ cycles since entry) where the
  // transaction completes or times out, and how long bus_req_o stays high.
  function automatic plan_t make_plan(bit we, logic [31:0] addr, logic [3:0] be,
                                      logic [31:0] wd, int a, int r, logic [31:0] d);
    plan_t p;
    p.we = we; p.addr = addr; p.be = be; p.wdata = wd;
    p.a = a; p.r = r; p.d = d;
    p.reqlen = (a >= 0 && a <= T - 1) ? a + 1 : T;
    if (a >= 0 && a <= T - 1 && (we || (r >= 0 && a + r <= T - 1))) begin
      p.c     = we ? a : a + r;
      p.err   = 1'b0;
      p.rdata = we ? 32'h0 : d;
    end else begin
      p.c     = T - 1;
      p.err   = 1'b1;
      p.rdata = 32'h0;
    end
    return p;
  endfunction

  task automatic step();
    int k;
    @(posedge clk_gen);
    cyc++;
    xfer = 1'b0;
    if (!rst_i) begin
      if (cmd_valid_i && m_ready) begin
        cur = pend; P = cyc; active = 1'b1; xfer = 1'b1;
      end else if (active && cyc - P == cur.c + 1) begin
        m_err = cur.err; m_rdata = cur.rdata;
      end else if (active && cyc - P == cur.c + 2) begin
        active = 1'b0;
      end
      m_ready = !active;
    end
    #1;
    ack_win = 1'b0;
    bus_resp_i = 1'b0;
    bus_rdata_bi = $urandom;
    if (!rst_i) begin
      k = cyc - P;
      if (active) begin
        if (cur.a >= 0 && k >= cur.a) ack_win = 1'b1;
        if (!cur.we && cur.a >= 0 && cur.r >= 0 && k == cur.a + cur.r) begin
          bus_resp_i = 1'b1; bus_rdata_bi = cur.d;
        end
      end
      if (noise_en && $urandom_range(0, 3) == 0 &&
          (!active || cur.a < 0 || k < cur.a || k == cur.c + 1)) bus_resp_i = 1'b1;
      if (resp_force && !active) bus_resp_i = 1'b1;
    end
  endtask

  task automatic do_reset(int n);
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; ack_win = 1'b0; bus_resp_i = 1'b0;
    active = 1'b0; m_ready = 1'b1; m_err = 1'b0; m_rdata = '0;
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  task automatic issue(bit we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                       int a, int r, logic [31:0] d, bit keep);
    int n;
    n = 0;
    pend = make_plan(we, addr, be, wd, a, r, d);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wd;
    do begin
      step(); n++;
    end while (!xfer && n < 400);
    checks++;
    if (!xfer) begin
      errors++;
      $display("FAIL accept: no command transfer within %0d cycles", n);
    end
    if (!keep) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (active && n < 400) begin
      step(); n++;
    end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL idle_wait: transaction still open after %0d cycles", n);
    end
  endtask

  task automatic directed(string name, bit we, logic [31:0] addr, logic [3:0] be,
                          logic [31:0] wd, int a, int r, logic [31:0] d,
                          int lat, bit err, logic [31:0] rdata, int reqlen);
    int v0, t;
    v0 = vld_cnt;
    issue(we, addr, be, wd, a, r, d, 1'b0);
    t = P - 1;
    wait_idle();
    chk32({name, "_latency"}, 32'(last_vld_cyc - t), 32'(lat));
    chk1({name, "_err"}, last_err, err);
    chk32({name, "_rdata"}, last_rdata, rdata);
    chk32({name, "_req_cycles"}, 32'(last_req_len), 32'(reqlen));
    chk32({name, "_pulses"}, 32'(vld_cnt - v0), 32'd1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk1({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
    chk1({tag, "_res_valid"}, res_valid_o, 1'b0);
    chk1({tag, "_res_err"}, res_err_o, 1'b0);
    chk32({tag, "_res_rdata"}, res_rdata_o, 32'h0);
    chk1({tag, "_bus_req"}, bus_req_o, 1'b0);
    chk1({tag, "_bus_we"}, bus_we_o, 1'b0);
    chk32({tag, "_bus_addr"}, bus_addr_bo, 32'h0);
    chk32({tag, "_bus_be"}, 32'(bus_be_bo), 32'h0);
    chk32({tag, "_bus_wdata"}, bus_wdata_bo, 32'h0);
  endtask

  task automatic run_random(int n);
    int sel, a, r, v0;
    bit we, keep;
    v0 = vld_cnt;
    for (int i = 0; i < n; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 11);
      if (sel < 7)       a = $urandom_range(0, 3);
      else if (sel < 9)  a = $urandom_range(4, 12);
      else if (sel == 9) a = -1;
      else               a = $urandom_range(95, 101);
      r = (sel == 6) ? $urandom_range(96, 100) - a : $urandom_range(0, 4);
      keep = 1'($urandom_range(0, 1));
      issue(we, $urandom, 4'($urandom), $urandom, a, r, $urandom, keep);
      if (!keep) repeat ($urandom_range(0, 2)) step();
    end
    cmd_valid_i = 1'b0;
    wait_idle();
    chk32("rand_pulses", 32'(vld_cnt - v0), 32'(n));
  endtask

  always @(negedge clk_gen) begin : cmp
    int k;
    bit ereq, evld;
    k    = cyc - P;
    ereq = active && k >= 0 && k < cur.reqlen;
    evld = active && k == cur.c + 1;
    chk1("cmd_ready", cmd_ready_o, m_ready);
    chk1("res_valid", res_valid_o, evld);
    chk1("bus_req", bus_req_o, ereq);
    chk1("res_err", res_err_o, m_err);
    chk32("res_rdata", res_rdata_o, m_rdata);
    if (ereq) begin
      chk1("bus_we", bus_we_o, cur.we);
      chk32("bus_addr", bus_addr_bo, cur.addr);
      chk32("bus_be", 32'(bus_be_bo), 32'(cur.be));
      chk32("bus_wdata", bus_wdata_bo, cur.wdata);
    end
    if (res_valid_o) begin
      vld_cnt++; last_vld_cyc = cyc; last_err = res_err_o; last_rdata = res_rdata_o;
    end
    if (bus_req_o) req_run++;
    else if (req_run != 0) begin
      last_req_len = req_run; req_run = 0;
    end
  end

  initial begin
    int v0;
    #1;
    do_reset(3);
    @(negedge clk_gen);
    chk_reset_vals("por");

    directed("wr_basic", 1'b1, 32'h0, 4'hF, 32'hA5, 0, 0, 32'h0, 2, 1'b0, 32'h0, 1);
    directed("rd_basic", 1'b0, 32'h80000004, 4'hF, 32'h0, 0, 2, 32'hDEADBEEF,
             4, 1'b0, 32'hDEADBEEF, 1);
    directed("wr_timeout", 1'b1, 32'h40, 4'h1, 32'h5A, -1, 0, 32'h0, 101, 1'b1, 32'h0, 100);
    directed("rd_race", 1'b0, 32'h44, 4'hF, 32'h0, 0, 99, 32'h0BADF00D,
             101, 1'b0, 32'h0BADF00D, 1);
    directed("wr_last_ack", 1'b1, 32'h48, 4'h6, 32'h77, 99, 0, 32'h0, 101, 1'b0, 32'h0, 100);
    directed("rd_late_resp", 1'b0, 32'h4C, 4'hF, 32'h0, 0, 100, 32'h11223344,
             101, 1'b1, 32'h0, 1);
    noise_en = 1'b1;
    directed("rd_late_ack", 1'b0, 32'h50, 4'h3, 32'h0, 3, 0, 32'h12345678,
             5, 1'b0, 32'h12345678, 4);
    directed("rd_wait", 1'b0, 32'h54, 4'hC, 32'h0, 1, 3, 32'hA5A55A5A,
             6, 1'b0, 32'hA5A55A5A, 2);
    noise_en = 1'b0;

    v0 = vld_cnt;
    issue(1'b0, 32'h80000004, 4'hF, 32'h0, 0, 50, 32'hCAFEF00D, 1'b0);
    repeat (4) step();
    do_reset(2);
    resp_force = 1'b1;
    repeat (4) step();
    resp_force = 1'b0;
    @(negedge clk_gen);
    chk_reset_vals("mid_rst");
    chk32("mid_rst_pulses", 32'(vld_cnt - v0), 32'd0);

    v0 = vld_cnt;
    issue(1'b1, 32'h100, 4'h3, 32'h11111111, 0, 0, 32'h0, 1'b1);
    issue(1'b1, 32'h104, 4'hC, 32'h22222222, 3, 0, 32'h0, 1'b1);
    issue(1'b1, 32'h108, 4'hF, 32'h33333333, 0, 0, 32'h0, 1'b0);
    wait_idle();
    chk32("b2b_pulses", 32'(vld_cnt - v0), 32'd3);

    noise_en = 1'b1;
    run_random(40);
    noise_en = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
